// File: rtl/instr_encoder_loader.sv
// Takes decoded instruction fields over a valid/ready handshake, encodes them
// into 32-bit MIPS-style words and writes them to consecutive memory addresses.
module instr_encoder_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  state_t      state;
  state_t      next_state;
  logic        xfer;
  logic        legal;
  logic [3:0]  op_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [15:0] imm_q;
  logic [25:0] target_q;
  logic [31:0] encoded;

  assign xfer  = in_valid & in_ready;
  assign legal = (op_sel <= 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (xfer && legal) next_state = ENC;
      ENC:     next_state = WR;
      WR:      next_state = (count == LAST_CNT) ? FULL : IDLE;
      FULL:    next_state = FULL;
      default: next_state = IDLE;
    endcase
    // clear overrides everything, including a same-edge transfer
    if (clear) next_state = IDLE;
  end

  always_comb begin
    in_ready = (state == IDLE);
    full     = (state == FULL);
  end

  always_comb begin
    encoded = '0;
    case (op_q)
      4'd0:    encoded = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'h20};
      4'd1:    encoded = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'h22};
      4'd2:    encoded = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'h18};
      4'd3:    encoded = {6'd0, rs_q, rt_q, rd_q, 5'd0, 6'h2A};
      4'd4:    encoded = {6'd8,  rs_q, rt_q, imm_q};
      4'd5:    encoded = {6'd35, rs_q, rt_q, imm_q};
      4'd6:    encoded = {6'd43, rs_q, rt_q, imm_q};
      4'd7:    encoded = {6'd4,  rs_q, rt_q, imm_q};
      4'd8:    encoded = {6'd2, target_q};
      default: encoded = '0;
    endcase
  end

  // mem_we is registered at the end of WR, so address and count advance one
  // edge later, keeping mem_addr stable for the whole write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      target_q  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      count     <= '0;
    end else begin
      mem_we <= 1'b0;
      err    <= 1'b0;
      if (clear) begin
        mem_addr <= '0;
        count    <= '0;
      end else begin
        if (state == IDLE && xfer) begin
          if (legal) begin
            op_q     <= op_sel;
            rs_q     <= rs;
            rt_q     <= rt;
            rd_q     <= rd;
            imm_q    <= imm;
            target_q <= target;
          end else begin
            err <= 1'b1;
          end
        end
        if (state == ENC) mem_wdata <= encoded;
        if (state == WR)  mem_we    <= 1'b1;
        if (mem_we) begin
          count <= count + 1'b1;
          if (count != LAST_CNT) mem_addr <= mem_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed table, randomized
// transfers against an arithmetic encoding model, and clear/reset corner cases.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        op_sel = '0;
  logic [4:0]        rs = '0;
  logic [4:0]        rt = '0;
  logic [4:0]        rd = '0;
  logic [15:0]       imm = '0;
  logic [25:0]       target = '0;
  logic              clear = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_word;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", nm, act);
    end
  endtask

  // Reference encoding from the field-placement rules, using plain arithmetic.
  function automatic logic [31:0] ref_word(input int op, input int a, input int b,
                                           input int c, input int i, input int t);
    int funct_of[4] = '{32, 34, 24, 42};
    int opc_of[4]   = '{8, 35, 43, 4};
    longint w;
    if (op < 4)
      w = longint'(a) * 2097152 + longint'(b) * 65536 + longint'(c) * 2048 + funct_of[op];
    else if (op < 8)
      w = longint'(opc_of[op-4]) * 67108864 + longint'(a) * 2097152 + longint'(b) * 65536 + i;
    else
      w = longint'(2) * 67108864 + t;
    return w[31:0];
  endfunction

  task automatic scramble();
    op_sel = 4'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
  endtask

  // One handshake; legal ops are followed through ENC/WR, illegal ones through err.
  task automatic xfer(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [15:0] i, input logic [25:0] t,
                      input logic [31:0] exp_word, input string name);
    chk({name, " in_ready before"}, in_ready, 1);
    op_sel = op; rs = a; rt = b; rd = c; imm = i; target = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    if (op > 4'd8) begin
      chk({name, " err pulse"}, err, 1);
      chk({name, " in_ready stays"}, in_ready, 1);
      chk({name, " no mem_we"}, mem_we, 0);
      @(posedge clk); #1;
      chk({name, " err cleared"}, err, 0);
      chk({name, " no mem_we 2"}, mem_we, 0);
      chk({name, " count held"}, count, model_count);
    end else begin
      chk({name, " ENC in_ready"}, in_ready, 0);
      chk({name, " ENC count"}, count, model_count);
      chk({name, " ENC mem_we"}, mem_we, 0);
      @(posedge clk); #1;
      chk({name, " WR mem_we"}, mem_we, 0);
      @(posedge clk); #1;
      chk({name, " mem_we"}, mem_we, 1);
      chk({name, " mem_wdata"}, mem_wdata, exp_word);
      chk({name, " mem_addr"}, mem_addr, model_count);
      model_count++;
    end
  endtask

  task automatic rand_xfer(input int idx, input bit allow_illegal);
    logic [3:0] op;
    logic [4:0] a, b, c;
    logic [15:0] i;
    logic [25:0] t;
    if (allow_illegal && ($urandom % 4 == 0)) op = 4'($urandom_range(9, 15));
    else op = 4'($urandom_range(0, 8));
    a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
    i = 16'($urandom); t = 26'($urandom);
    xfer(op, a, b, c, i, t, ref_word(op, a, b, c, i, t), $sformatf("rand%0d op%0d", idx, op));
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, " in_ready"}, in_ready, 1);
    chk({nm, " mem_we"}, mem_we, 0);
    chk({nm, " mem_addr"}, mem_addr, 0);
    chk({nm, " mem_wdata"}, mem_wdata, 0);
    chk({nm, " count"}, count, 0);
    chk({nm, " full"}, full, 0);
    chk({nm, " err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820, "add"};
    vecs[1] = '{4'd5, 5'd29, 5'd8,  5'd31, 16'h0004, 26'h3FFFFFF, 32'h8FA80004, "lw"};
    vecs[2] = '{4'd7, 5'd1,  5'd2,  5'd17, 16'hFFFF, 26'h1555555, 32'h1022FFFF, "beq"};
    vecs[3] = '{4'd8, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h08000010, "j"};
    vecs[4] = '{4'd1, 5'd4,  5'd5,  5'd6,  16'h1234, 26'h0ABCDEF, 32'h00853022, "sub"};
    vecs[5] = '{4'd2, 5'd7,  5'd8,  5'd9,  16'h0000, 26'h0000000, 32'h00E84818, "mul"};
    vecs[6] = '{4'd3, 5'd31, 5'd0,  5'd31, 16'hAAAA, 26'h2222222, 32'h03E0F82A, "slt"};
    vecs[7] = '{4'd4, 5'd2,  5'd3,  5'd31, 16'h8000, 26'h3FFFFFF, 32'h20438000, "addi"};
    vecs[8] = '{4'd6, 5'd29, 5'd31, 5'd0,  16'h0010, 26'h0000000, 32'hAFBF0010, "sw"};
    // j ignores rs/rt/rd/imm: fill them randomly
    vecs[3].rs = 5'($urandom); vecs[3].rt = 5'($urandom);
    vecs[3].rd = 5'($urandom); vecs[3].imm = 16'($urandom);

    #1 rst = 1'b1;
    #1 chk_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 9; k++)
      xfer(vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].imm, vecs[k].target,
           vecs[k].exp_word, vecs[k].name);

    xfer(4'd12, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1, 32'h0, "illegal12");

    for (int k = 0; k < DEPTH - 9; k++) rand_xfer(k, 1'b0);

    @(posedge clk); #1;
    chk("full flag", full, 1);
    chk("full in_ready", in_ready, 0);
    chk("full count", count, DEPTH);
    chk("full mem_addr", mem_addr, DEPTH - 1);

    op_sel = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("17th mem_we c%0d", k), mem_we, 0);
      chk($sformatf("17th in_ready c%0d", k), in_ready, 0);
    end
    in_valid = 1'b0;
    chk("17th mem_addr held", mem_addr, DEPTH - 1);
    chk("17th count held", count, DEPTH);

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_count = 0;
    chk("clear mem_addr", mem_addr, 0);
    chk("clear count", count, 0);
    chk("clear in_ready", in_ready, 1);
    chk("clear full", full, 0);

    for (int k = 0; k < 10; k++) rand_xfer(100 + k, 1'b1);

    // clear while a word is in ENC (d=0) or WR (d=1)
    for (int d = 0; d < 2; d++) begin
      op_sel = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (d) begin @(posedge clk); #1; end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_count = 0;
      chk($sformatf("midclear%0d in_ready", d), in_ready, 1);
      chk($sformatf("midclear%0d count", d), count, 0);
      chk($sformatf("midclear%0d mem_addr", d), mem_addr, 0);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("midclear%0d no mem_we c%0d", d, k), mem_we, 0);
        @(posedge clk); #1;
      end
    end

    op_sel = 4'd5; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    chk("clear+xfer in_ready", in_ready, 1);
    chk("clear+xfer err", err, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("clear+xfer no mem_we c%0d", k), mem_we, 0);
    end
    chk("clear+xfer count", count, 0);

    xfer(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, "add after clear");
    @(posedge clk); #1;
    chk("count before rst", count, 1);

    op_sel = 4'd4; rs = 5'd3; rt = 5'd4; imm = 16'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_values("rst midENC");
    @(posedge clk); #1;
    rst = 1'b0;
    model_count = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("after rst no mem_we c%0d", k), mem_we, 0);
    end
    chk("after rst count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  16  instruction-memory words the loader fills
  ADDR_W  4  address width; the relation DEPTH <= 2**ADDR_W SHALL hold.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state changes on its rising edge
  rst  in  1  asynchronous, active-high reset
  in_valid  in  1  instruction fields present
  in_ready  out  1  loader can accept fields
  op_sel  in  4  0 add, 1 sub, 2 mul, 3 slt, 4 addi, 5 lw, 6 sw, 7 beq, 8 j; 9-15 illegal
  rs  in  5  source register
  rt  in  5  second source register or destination register
  rd  in  5  R-type destination register
  imm  in  16  I-type immediate
  target  in  26  J-type target
  clear  in  1  synchronous restart of the load address
  mem_we  out  1  instruction-memory write strobe
  mem_addr  out  ADDR_W  write address
  mem_wdata  out  32  encoded instruction word
  count  out  ADDR_W+1  words written since reset or clear
  full  out  1  DEPTH words written
  err  out  1  one-cycle pulse on an illegal op_sel

Function
REQ-003 The handshake SHALL transfer when in_valid=1 and in_ready=1 on a rising edge; fields SHALL be sampled only on that edge.
REQ-004 FSM states SHALL be IDLE, ENC, WR and FULL.
REQ-005 In IDLE, in_ready=1; a transfer with a legal op_sel SHALL go to ENC.
REQ-006 A transfer with an illegal op_sel SHALL pulse err for 1 cycle, stay in IDLE and not write.
REQ-007 In ENC, in_ready=0; the encoded word SHALL be registered into mem_wdata; next state WR.
REQ-008 In WR, mem_we=1 for exactly 1 cycle with the current mem_addr; count then increments; next state SHALL be FULL if count reaches DEPTH, else IDLE with mem_addr+1.
REQ-009 Latency: a transfer at edge N SHALL give mem_we high in the cycle after edge N+2; throughput SHALL be 1 word per 3 cycles.
REQ-010 In FULL, full=1 and in_ready=0; mem_addr SHALL hold DEPTH-1; in_valid SHALL be ignored.
REQ-011 R-type (op_sel 0-3) SHALL encode as opcode 0, rs[25:21], rt[20:16], rd[15:11], shamt 0, funct 0x20 add, 0x22 sub, 0x18 mul, 0x2A slt.
REQ-012 I-type SHALL encode as opcode[31:26], rs[25:21], rt[20:16], imm[15:0], with opcode 8 addi, 35 lw, 43 sw, 4 beq.
REQ-013 J-type SHALL encode as opcode 2 and target[25:0]; rs, rt, rd and imm SHALL not affect the word.
REQ-014 R-type words SHALL ignore imm and target; I-type words SHALL ignore rd and target.
REQ-015 clear=1 in any state SHALL set mem_addr=0 and count=0 and go to IDLE on the next edge; an in-flight ENC/WR word SHALL be discarded with no mem_we.
REQ-016 If clear and a transfer occur on the same edge, clear SHALL win and the fields SHALL be dropped.
REQ-017 The address SHALL never wrap; overflow is prevented by the FULL state.

Reset
REQ-018 With rst=1, the block SHALL immediately go to IDLE, regardless of clk, with in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0 and err=0.
REQ-019 Reset during ENC/WR SHALL abort the word with no mem_we pulse after rst asserts.

Verification
REQ-020 The bench SHALL cover these scenarios:
  add rd=3, rs=1, rt=2 -> mem_wdata=0x00221820, mem_addr=0, mem_we high in the cycle after edge N+2, count=1.
  lw rt=8, rs=29, imm=4, then beq rs=1, rt=2, imm=0xFFFF -> 0x8FA80004 at addr 0, 0x1022FFFF at addr 1.
  j target=0x10 with random rs/rt/rd/imm -> 0x08000010.
  op_sel=12 -> err high 1 cycle, no mem_we, count unchanged, in_ready stays 1.
  16 legal transfers -> addresses 0..15, full=1, in_ready=0 after the 16th mem_we; a 17th in_valid causes no write; clear -> mem_addr=0, count=0, in_ready=1.
  rst asserted mid-ENC -> outputs at reset values before the next clk edge, no mem_we.
